mem_store_buffer: RTL
=====================

Name: mem_store_buffer

Overview:
Store-side counterpart to the MEM-stage load extender. Accepts sw/sh/sb requests from the MEM stage and converts them to word-aligned address, lane-replicated write data and 4-bit byte enables. Buffers them in a small FIFO and drains them to data memory over a valid/ready handshake. Flags loads that hit a word with a pending store so the pipeline can stall them.

Parameters:
DEPTH, 4, number of buffered stores; must be a power of 2 and at least 2.
AW, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
st_valid  in  1  MEM stage presents a store this cycle.
st_op  in  2  store kind: 00 sw, 01 sh, 10 sb; 11 is reserved.
st_addr  in  32  byte address from the EX result.
st_data  in  32  unaligned rt value.
st_pc  in  32  PC of the store instruction.
st_ready  out  1  buffer can accept a store; MEM stage stalls while low.
m_valid  out  1  head entry is valid toward memory.
m_ready  in  1  memory accepts the head entry.
m_addr  out  32  word address {addr[31:2],2'b00}.
m_wdata  out  32  lane-aligned write data.
m_byteen  out  4  byte enables.
m_pc  out  32  PC of the head store, for trace.
ld_valid  in  1  a load is in the MEM stage.
ld_addr  in  32  load byte address.
ld_hazard  out  1  load overlaps a pending store.
buf_empty  out  1  no pending stores.
st_exc  out  1  misaligned-store exception pulse (see Optional Feature).
st_badvaddr  out  32  faulting address for st_exc.

Behaviour:
- Reset (async, rst_n=0): head/tail pointers, count, m_valid, st_exc and st_badvaddr all go to 0; buf_empty=1; st_ready=1; entry storage is not cleared.
- Storage: count register is AW+1 bits wide; full when count==DEPTH. Pointers wrap modulo DEPTH.
- st_ready = (count != DEPTH). A store is accepted when st_valid && st_ready.
- st_op=11 is accepted as a no-op: nothing is enqueued.
- Push: writes the aligned entry {m_addr, m_wdata, m_byteen, pc} at the tail, then tail+1.
- Alignment, with a = st_addr[1:0]:
  - sw: byteen 1111, wdata = st_data.
  - sh: byteen 1100 if a[1], else 0011; wdata = {2{st_data[15:0]}}.
  - sb: byteen = 0001<<a; wdata = {4{st_data[7:0]}}.
- Drain: m_valid = (count != 0), driven from registered state. m_* fields come from the head entry. Pop on m_valid && m_ready, then head+1.
- Latency: a store accepted in cycle N is visible on m_valid in cycle N+1 at the earliest.
- No combinational path from st_valid to m_valid, or from m_ready to st_ready.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- When full, st_ready=0 even if a pop occurs in the same cycle. The push is taken on the next cycle.
- m_* holds stable while m_valid && !m_ready.
- ld_hazard (combinational) = ld_valid && some valid entry has m_addr == {ld_addr[31:2],2'b00} and a nonzero byteen. This is word-granular and conservative.
- The buffer never reorders entries and never drops an accepted entry.
- buf_empty = (count == 0), used by the pipeline before eret/syscall.

Optional Feature:
STORE_ALIGN_EXC_EN
- Defined: sw with a != 00, or sh with a[0]=1, is not enqueued. The store is still handshaken (st_ready governs) so the MEM stage advances.
  - st_exc pulses high for exactly 1 cycle, the cycle after acceptance.
  - st_badvaddr is registered to st_addr and holds until the next exception.
- Undefined: the low address bits are ignored for alignment checks (sw is treated as a=00, sh uses a[1] only). st_exc and st_badvaddr are tied to 0.

Decomposition:
- Shared package/const header holds: ST_SW/ST_SH/ST_SB/ST_NONE op encodings, the byteen constants, and EXC_ADES=5'd5.
- Single sub-module store_align: combinational (op, addr[1:0], data) -> (byteen, wdata, misaligned flag).
- FIFO storage and control stay inline.

Test Plan:
- Reset then sb addr 0x1003 data 0xAB -> next cycle m_valid=1, m_addr 0x1000, m_byteen 1000, m_wdata 0xABABABAB.
- sh addr 0x2002 data 0x1234BEEF, then sw 0x2004 data 0xCAFEF00D with m_ready=1 -> in-order outputs: (0x2000, 1100, 0xBEEFBEEF), then (0x2004, 1111, 0xCAFEF00D).
- m_ready=0, push 4 stores -> st_ready=0 after the 4th. Fifth st_valid is held; raise m_ready for 1 cycle -> 1 pop, and the fifth is accepted the following cycle; count stays 4.
- Pending sw to 0x3000, ld_valid with ld_addr 0x3002 -> ld_hazard=1; ld_addr 0x3004 -> 0; after drain, 0x3002 -> 0.
- Assert rst_n low mid-drain with 3 entries queued -> m_valid=0 immediately (async), buf_empty=1, st_ready=1; no entry is emitted after release.
- With STORE_ALIGN_EXC_EN defined: sw addr 0x4001 -> st_exc=1 for one cycle, st_badvaddr=0x4001, nothing enqueued. Without it: an entry is enqueued with m_addr 0x4000, byteen 1111.

Source files
------------

// File: rtl/mem_store_buffer_pkg.sv
// Shared store-buffer definitions: store op encodings, byte-enable patterns, exception code
// and the buffered entry layout.
package mem_store_buffer_pkg;

    typedef enum logic [1:0] {
        ST_SW   = 2'b00,
        ST_SH   = 2'b01,
        ST_SB   = 2'b10,
        ST_NONE = 2'b11
    } st_op_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE    = 4'b0001;

    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
        logic [31:0] pc;
    } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_store_align.sv
// Combinational store lane alignment: op + low address bits -> byte enables, replicated data.
// Misalignment is only reported when STORE_ALIGN_EXC_EN is defined.
module store_align
    import mem_store_buffer_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  byteen,
    output logic [31:0] wdata,
    output logic        misaligned
);

    always_comb begin
        byteen     = BE_WORD;
        wdata      = data;
        misaligned = 1'b0;
        case (op)
            ST_SW: begin
`ifdef STORE_ALIGN_EXC_EN
                misaligned = (addr_lo != 2'b00);
`endif
            end
            ST_SH: begin
                byteen = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata  = {2{data[15:0]}};
`ifdef STORE_ALIGN_EXC_EN
                misaligned = addr_lo[0];
`endif
            end
            ST_SB: begin
                byteen = BE_BYTE << addr_lo;
                wdata  = {4{data[7:0]}};
            end
            default: begin
                byteen = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: aligns sw/sh/sb, queues them in a DEPTH-entry FIFO, drains over valid/ready
// and flags loads to pending words. Optional misaligned-store exception via STORE_ALIGN_EXC_EN.
module mem_store_buffer
    import mem_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_pc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        buf_empty,
    output logic        st_exc,
    output logic [31:0] st_badvaddr
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    sb_entry_t      mem [DEPTH];
    logic [AW-1:0]  head, tail;
    logic [AW:0]    count;
    logic [3:0]     al_byteen;
    logic [31:0]    al_wdata;
    logic           misaligned;
    logic           accept, push, pop;
    logic [DEPTH-1:0] hit;

    store_align u_align (
        .op         (st_op),
        .addr_lo    (st_addr[1:0]),
        .data       (st_data),
        .byteen     (al_byteen),
        .wdata      (al_wdata),
        .misaligned (misaligned)
    );

    // st_ready and m_valid depend only on registered count, so no in->out combinational path.
    assign st_ready  = (count != CNT_FULL);
    assign m_valid   = (count != '0);
    assign buf_empty = (count == '0);
    assign accept    = st_valid && st_ready;
    assign push      = accept && (st_op != ST_NONE) && !misaligned;
    assign pop       = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{addr: {st_addr[31:2], 2'b00}, wdata: al_wdata,
                                 byteen: al_byteen, pc: st_pc};
    end

    assign m_addr   = mem[head].addr;
    assign m_wdata  = mem[head].wdata;
    assign m_byteen = mem[head].byteen;
    assign m_pc     = mem[head].pc;

    // An entry is live when its distance from head is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_hit
        logic [AW-1:0] offs;
        assign offs   = AW'(g) - head;
        assign hit[g] = ({1'b0, offs} < count) &&
                        (((mem[g].addr ^ ld_addr) & WORD_MASK) == 32'h0) &&
                        (mem[g].byteen != 4'b0000);
    end

    assign ld_hazard = ld_valid && (|hit);

`ifdef STORE_ALIGN_EXC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_exc      <= 1'b0;
            st_badvaddr <= '0;
        end else begin
            st_exc <= accept && misaligned;
            if (accept && misaligned) st_badvaddr <= st_addr;
        end
    end
`else
    assign st_exc      = 1'b0;
    assign st_badvaddr = '0;
`endif

endmodule
